// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
// Data width, register address width and the default starvation limit.
package rvx10_pkg;

    localparam int XLEN             = 32;
    localparam int REG_AW           = 5;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback, long-latency, decode and regfile-port signals.
// master drives requests; slave is the arbiter.
interface rf_wb_if;
    import rvx10_pkg::*;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              lu_valid;
    logic              lu_ready;
    logic [REG_AW-1:0] lu_rd;
    logic [XLEN-1:0]   lu_data;

    logic              iss_valid;
    logic [REG_AW-1:0] iss_rd;

    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_hazard;

    logic              bubble_req;

    logic              we3;
    logic [REG_AW-1:0] a3;
    logic [XLEN-1:0]   wd3;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output lu_valid, lu_rd, lu_data,
        output iss_valid, iss_rd,
        output dec_rs1, dec_rs2, dec_rd,
        input  lu_ready, dec_hazard, bubble_req,
        input  we3, a3, wd3
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  lu_valid, lu_rd, lu_data,
        input  iss_valid, iss_rd,
        input  dec_rs1, dec_rs2, dec_rd,
        output lu_ready, dec_hazard, bubble_req,
        output we3, a3, wd3
    );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Small result FIFO for long-latency writebacks.
// Power-of-two depth, wrapping pointers, registered occupancy count.
module rf_wb_fifo
    import rvx10_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [XLEN-1:0]   push_data,
    input  logic              pop,
    output logic [REG_AW-1:0] head_rd,
    output logic [XLEN-1:0]   head_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = rd_mem[rptr];
    assign head_data = data_mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wptr]   <= push_rd;
            data_mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: pipeline WB has priority, long-latency
// results queue in a FIFO; a pending scoreboard drives decode stalls.
module rf_wb_arbiter
    import rvx10_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic clk,
    input logic reset,
    rf_wb_if.slave bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic              full;
    logic              empty;
    logic              ready;
    logic              push;
    logic              pop;
    logic              fifo_write;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    wb_req_t           pipe_req;
    wb_req_t           head_req;
    wb_req_t           sel;
    logic [SW-1:0]     starve;
    logic [31:0]       pending;
    logic [31:0]       set_mask;
    logic [31:0]       clr_mask;
    logic [31:0]       live;

    assign ready        = !full && !reset;
    assign push         = bus.lu_valid && ready;
    assign bus.lu_ready = ready;

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_rd   (bus.lu_rd),
        .push_data (bus.lu_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (full),
        .empty     (empty)
    );

    // Port selection: pipeline first, else drain the FIFO head.
    always_comb begin
        pipe_req.valid = bus.wb_valid && (bus.wb_rd != '0);
        pipe_req.rd    = bus.wb_rd;
        pipe_req.data  = bus.wb_data;
        head_req.valid = !empty && (head_rd != '0);
        head_req.rd    = head_rd;
        head_req.data  = head_data;
        sel            = '0;
        pop            = 1'b0;
        if (reset) begin
            sel = '0;
        end else if (pipe_req.valid) begin
            sel = pipe_req;
        end else if (!empty) begin
            pop = 1'b1;
            if (head_req.valid) begin
                sel = head_req;
            end
        end
    end

    assign fifo_write = pop && head_req.valid;
    assign bus.we3    = sel.valid;
    assign bus.a3     = sel.rd;
    assign bus.wd3    = sel.data;

    // Scoreboard set/clear masks for this cycle.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            set_mask[bus.iss_rd] = 1'b1;
        end
        if (fifo_write) begin
            clr_mask[head_rd] = 1'b1;
        end
        live = pending & ~clr_mask;
    end

    // Pending bits: set beats clear; x0 never pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    // A register being written this cycle is readable via the
    // negedge regfile write, so it no longer stalls decode.
    assign bus.dec_hazard = !reset &&
        (live[bus.dec_rs1] | live[bus.dec_rs2] | live[bus.dec_rd]);

    // Count cycles the FIFO head loses to the pipeline; saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve <= '0;
        end else if (empty || pop) begin
            starve <= '0;
        end else if (pipe_req.valid && (starve != SW'(STARVE_LIMIT))) begin
            starve <= starve + SW'(1);
        end
    end

    assign bus.bubble_req = !reset && (starve == SW'(STARVE_LIMIT));

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (a3/we3/wd3, written on negedge clk) between the in-order pipeline writeback stage and a multi-cycle long-latency unit (MUL/DIV).
- Buffers long-latency results in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on RAW/WAW against in-flight long-latency ops.
- Sits between the writeback stage, the long-latency unit, the hazard unit and regfile.

Parameters:
- XLEN, 32, data width
- DEPTH, 4, result FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles FIFO head may be denied before a bubble is requested

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  pipeline writeback wants to write
- wb_rd  in  5  pipeline destination
- wb_data  in  XLEN  pipeline result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO accepts result
- lu_rd  in  5  long-latency destination
- lu_data  in  XLEN  long-latency result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  5  its destination
- dec_rs1  in  5  decode source 1
- dec_rs2  in  5  decode source 2
- dec_rd  in  5  decode destination
- dec_hazard  out  1  decode must stall
- bubble_req  out  1  ask pipeline to insert a WB bubble
- we3  out  1  regfile write enable
- a3  out  5  regfile write address
- wd3  out  XLEN  regfile write data

Behaviour:
- Reset (sync):
  - FIFO empty, all pending bits 0, starve counter 0.
  - we3=0, bubble_req=0, dec_hazard=0, lu_ready=0 while reset high.
- FIFO:
  - lu_ready = !full && !reset.
  - Push on lu_valid&&lu_ready.
  - Head is visible the cycle after push (earliest regfile write at push+1).
  - Pointers wrap modulo DEPTH; a count register gives full/empty.
  - Push and pop in the same cycle when full: the pop frees the slot, but lu_ready still reflects the registered full flag, so no push occurs that cycle.
- Port selection (combinational):
  - wb_pipe = wb_valid && wb_rd!=0. x0 writes are dropped and do not use the port.
  - If wb_pipe: we3=1, a3=wb_rd, wd3=wb_data. FIFO is not popped.
  - Else if FIFO non-empty: pop head. If head rd!=0: we3=1, a3=head rd, wd3=head data. A head with rd==0 is popped with we3=0.
  - Else we3=0, and a3/wd3 are don't-care (drive 0).
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and wb_pipe=1. It clears on any pop or when empty, and saturates at STARVE_LIMIT.
  - bubble_req = (counter==STARVE_LIMIT). Registered, so it asserts the cycle after the limit is reached.
  - The pipeline must then present wb_valid=0 for at least one cycle. The pop occurs, the counter clears, and bubble_req drops the next cycle.
- Scoreboard (pending[31:1], pending[0] hardwired 0):
  - Set on iss_valid && iss_rd!=0.
  - Clear when the port writes from the FIFO to that rd.
  - Set and clear of the same rd in one cycle: set wins.
- dec_hazard (combinational):
  - Asserts if pending[rs1] | pending[rs2] | pending[rd], excluding a register being cleared this cycle.
  - The exclusion is safe because the regfile writes on negedge, so decode reads the new value the same cycle.
- A pipeline WB to a pending register is illegal (decode prevents it). The scoreboard is unaffected; the bench flags it with an assertion.
- Reset mid-operation discards FIFO contents and pending bits; no write is issued during reset.

Decomposition:
- Package rvx10_pkg: XLEN, REG_AW=5, the wb_req_t struct {valid, rd, data}, and a STARVE_LIMIT default constant.
- One sub-module, rf_wb_fifo (DEPTH x {rd,data}, registered count, full/empty).
- Arbitration, scoreboard and starve counter stay in the top.

Test Plan:
- Reset, then lu push rd=5 data=0xDEAD with wb_valid=0 -> cycle+1: we3=1, a3=5, wd3=0xDEAD; pending[5] 1->0.
- iss_rd=7, then dec_rs1=7 -> dec_hazard=1 until the FIFO writes rd=7; in the write cycle dec_hazard=0.
- wb_valid=1 wb_rd=3 continuously with 1 FIFO entry -> pipeline wins each cycle; bubble_req=1 after 8 denied cycles. Drop wb_valid one cycle -> FIFO entry written, bubble_req=0 next cycle.
- Push 4 entries with WB busy -> lu_ready=0 on full. Pop one -> lu_ready=1 the following cycle. Entries drain in order rd=1,2,3,4.
- wb_valid=1 wb_rd=0 with FIFO head rd=9 -> FIFO wins (a3=9). Head rd=0 -> popped with we3=0.
- Assert reset with 2 FIFO entries and pending[4]=1 -> next cycle empty, pending=0, we3=0, lu_ready=1 after release.
